// File: rtl/mem_responder.sv
// Word-addressed memory responder: req/ack handshake with a fixed number of
// wait states, byte-lane writes and out-of-range fault reporting.
module mem_responder #(
    parameter int WORDS       = 128,
    parameter int WAIT_STATES = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req,
    input  logic         write_en,
    input  logic [0:3]   byte_en,
    input  logic [15:31] address,
    input  logic [0:31]  data_in,
    output logic [0:31]  data_out,
    output logic         ack,
    output logic         fault
);

    localparam int          AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);
    localparam logic [31:0] DEPTH = 32'(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t       state;
    logic [3:0]   cnt;
    logic [16:0]  addr_r;
    logic         we_r;
    logic [0:3]   be_r;
    logic [0:31]  wdata_r;

    logic [0:31]  mem [WORDS];

    logic         commit;
    logic [16:0]  sel_addr;
    logic         sel_we;
    logic [0:3]   sel_be;
    logic [0:31]  sel_data;
    logic         in_range;
    logic [AW-1:0] idx;

    // With zero wait states the request commits on its accepting edge, so the
    // live bus is used; otherwise the latched copy is used.
    always_comb begin
        commit   = 1'b0;
        sel_addr = addr_r;
        sel_we   = we_r;
        sel_be   = be_r;
        sel_data = wdata_r;
        if (state == IDLE) begin
            commit   = req && (WS == 4'd0);
            sel_addr = address;
            sel_we   = write_en;
            sel_be   = byte_en;
            sel_data = data_in;
        end else if (state == WAIT) begin
            commit = (cnt <= 4'd1);
        end else begin
            commit = 1'b0;
        end
        in_range = ({15'd0, sel_addr} < DEPTH);
        idx      = sel_addr[AW-1:0];
    end

    // Storage array: not reset, written only on the edge that enters ACK.
    always_ff @(posedge clock) begin
        if (commit && sel_we && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_be[i]) begin
                    mem[idx][8*i +: 8] <= sel_data[8*i +: 8];
                end
            end
        end
    end

    // Handshake FSM with registered ack/fault/data_out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr_r   <= 17'd0;
            we_r     <= 1'b0;
            be_r     <= 4'd0;
            wdata_r  <= 32'd0;
            ack      <= 1'b0;
            fault    <= 1'b0;
            data_out <= 32'd0;
        end else begin
            ack   <= commit;
            fault <= commit && !in_range;
            if (commit && !in_range) begin
                data_out <= 32'd0;
            end else if (commit && !sel_we) begin
                data_out <= mem[idx];
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        addr_r  <= address;
                        we_r    <= write_en;
                        be_r    <= byte_en;
                        wdata_r <= data_in;
                        cnt     <= WS;
                        state   <= (WS == 4'd0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt <= 4'd1) begin
                        cnt   <= 4'd0;
                        state <= ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) checked against
// a word-array reference model with directed and random transactions.
module tb_mem_responder;

    logic         clock;
    logic         reset;
    logic         req    [2];
    logic         we     [2];
    logic [0:3]   be     [2];
    logic [15:31] addr   [2];
    logic [0:31]  din    [2];
    logic [0:31]  dout   [2];
    logic         ack    [2];
    logic         flt    [2];

    int ws [2] = '{2, 0};
    logic [31:0] mem_m  [2][128];
    logic [31:0] dout_m [2];
    int total = 0;
    int bad   = 0;

    mem_responder #(.WORDS(128), .WAIT_STATES(2)) u0 (
        .clock(clock), .reset(reset), .req(req[0]), .write_en(we[0]),
        .byte_en(be[0]), .address(addr[0]), .data_in(din[0]),
        .data_out(dout[0]), .ack(ack[0]), .fault(flt[0])
    );

    mem_responder #(.WORDS(128), .WAIT_STATES(0)) u1 (
        .clock(clock), .reset(reset), .req(req[1]), .write_en(we[1]),
        .byte_en(be[1]), .address(addr[1]), .data_in(din[1]),
        .data_out(dout[1]), .ack(ack[1]), .fault(flt[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete request on instance d; updates the model and checks the result.
    task automatic txn(input int d, input bit w, input logic [0:3] b,
                       input logic [16:0] a, input logic [31:0] wd);
        int  n;
        bit  got;
        bit  oor;
        logic [31:0] mask;
        @(negedge clock);
        req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; din[d] = wd;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clock); #1;
            n++;
            if (ack[d] === 1'b1) got = 1'b1;
        end
        req[d] = 1'b0;
        oor = (a >= 17'd128);
        if (oor) begin
            dout_m[d] = 32'd0;
        end else if (!w) begin
            dout_m[d] = mem_m[d][a[6:0]];
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (b[k]) begin
                    mask = 32'hFF << (24 - 8*k);
                    mem_m[d][a[6:0]] = (mem_m[d][a[6:0]] & ~mask) | (wd & mask);
                end
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        chk("latency", 32'(n), 32'(ws[d] + 1));
        chk("fault", 32'(flt[d]), 32'(oor));
        chk("data_out", dout[d], dout_m[d]);
        @(posedge clock); #1;
        chk("ack_one_cycle", 32'(ack[d]), 32'd0);
        chk("fault_only_with_ack", 32'(flt[d]), 32'd0);
    endtask

    initial begin
        int i, cyc, last;
        bit got;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'd0; addr[d] = 17'd0; din[d] = 32'd0;
            dout_m[d] = 32'd0;
            for (int j = 0; j < 128; j++) mem_m[d][j] = 32'd0;
        end
        reset = 1'b1;
        #23;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ack", 32'(ack[d]), 32'd0);
            chk("reset_fault", 32'(flt[d]), 32'd0);
            chk("reset_dout", dout[d], 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;

        // write then read, byte lanes
        txn(0, 1'b1, 4'hF, 17'd5, 32'hDEADBEEF);
        txn(0, 1'b0, 4'h0, 17'd5, 32'h0);
        chk("read_deadbeef", dout[0], 32'hDEADBEEF);
        txn(0, 1'b1, 4'b0101, 17'd5, 32'h11223344);
        txn(0, 1'b0, 4'hF, 17'd5, 32'h0);
        chk("byte_lanes", dout[0], 32'hDE22BE44);
        txn(0, 1'b1, 4'b0000, 17'd5, 32'h55555555);
        txn(0, 1'b0, 4'hF, 17'd5, 32'h0);
        chk("byte_en_zero", dout[0], 32'hDE22BE44);

        // out of range
        txn(0, 1'b0, 4'hF, 17'd128, 32'h0);
        txn(0, 1'b1, 4'hF, 17'd128, 32'hCAFEF00D);
        txn(0, 1'b1, 4'hF, 17'h1FFFF, 32'h12345678);
        txn(0, 1'b0, 4'hF, 17'd0, 32'h0);
        chk("addr0_untouched", dout[0], 32'h0);

        // back-to-back reads on the zero-wait-state instance
        for (int k = 0; k < 4; k++) txn(1, 1'b1, 4'hF, 17'(k), $urandom);
        @(negedge clock);
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'h0; addr[1] = 17'd0;
        i = 0; cyc = 0; last = 0;
        while (i < 4 && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
            if (ack[1] === 1'b1) begin
                chk("b2b_data", dout[1], mem_m[1][i]);
                if (i > 0) chk("b2b_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                i++;
                addr[1] = 17'(i);
                if (i == 4) req[1] = 1'b0;
            end
        end
        req[1] = 1'b0;
        chk("b2b_count", 32'(i), 32'd4);
        dout_m[1] = mem_m[1][3];

        // reset asserted mid-cycle while ack is high
        txn(0, 1'b0, 4'hF, 17'd5, 32'h0);
        @(negedge clock);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 17'd5;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
            if (ack[0] === 1'b1) got = 1'b1;
        end
        chk("pre_reset_ack", 32'(got), 32'd1);
        #2 reset = 1'b1;
        req[0] = 1'b0;
        #1;
        chk("async_reset_ack", 32'(ack[0]), 32'd0);
        chk("async_reset_fault", 32'(flt[0]), 32'd0);
        chk("async_reset_dout0", dout[0], 32'd0);
        chk("async_reset_dout1", dout[1], 32'd0);
        dout_m[0] = 32'd0; dout_m[1] = 32'd0;
        @(negedge clock);
        reset = 1'b0;

        // reset during the wait phase of a write
        @(negedge clock);
        req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 17'd7; din[0] = 32'h0000FFFF;
        @(posedge clock); #1;
        reset = 1'b1;
        req[0] = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            if (ack[0] === 1'b1) got = 1'b1;
        end
        chk("no_ack_after_reset", 32'(got), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        txn(0, 1'b0, 4'hF, 17'd7, 32'h0);
        chk("aborted_write", dout[0], 32'h00000000);

        // random traffic against the model
        for (int t = 0; t < 40; t++) begin
            int          d;
            logic [16:0] a;
            d = int'($urandom_range(1, 0));
            if ($urandom_range(9, 0) == 0) a = 17'(128 + $urandom_range(1000, 0));
            else                           a = 17'($urandom_range(127, 0));
            txn(d, 1'($urandom), 4'($urandom), a, $urandom);
        end
        for (int k = 0; k < 8; k++) txn(k % 2, 1'b0, 4'h0, 17'($urandom_range(127, 0)), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
